// File: rtl/eca_pkg.sv
// Shared encodings for the elementary cellular automaton engine:
// command opcodes, boundary modes, reset rule and controller states.
package eca_pkg;

   localparam logic [2:0] OP_NOP       = 3'd0;
   localparam logic [2:0] OP_WRITE     = 3'd1;
   localparam logic [2:0] OP_SET_RULE  = 3'd2;
   localparam logic [2:0] OP_SET_BMODE = 3'd3;
   localparam logic [2:0] OP_RUN_N     = 3'd4;
   localparam logic [2:0] OP_RUN_FREE  = 3'd5;
   localparam logic [2:0] OP_HALT      = 3'd6;
   localparam logic [2:0] OP_CLEAR     = 3'd7;

   localparam logic [1:0] BM_WRAP = 2'd0;
   localparam logic [1:0] BM_ZERO = 2'd1;
   localparam logic [1:0] BM_ONE  = 2'd2;

   localparam logic [7:0] RESET_RULE = 8'h6E;

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } state_t;

endpackage

// File: rtl/eca_step.sv
// One combinational generation of the automaton: every cell looks up
// rule[{right, self, left}] with the edges supplied by the boundary mode.
module eca_step
   import eca_pkg::*;
#(
   parameter int unsigned NUM_CELLS = 224
) (
   input  logic [NUM_CELLS-1:0] cells,
   input  logic [7:0]           rule,
   input  logic [1:0]           bmode,
   output logic [NUM_CELLS-1:0] nxt
);

   logic edge_lo;
   logic edge_hi;
   logic [NUM_CELLS+1:0] ext;

   always_comb begin
      edge_lo = 1'b0;
      edge_hi = 1'b0;
      case (bmode)
         BM_WRAP: begin
            edge_lo = cells[NUM_CELLS-1];
            edge_hi = cells[0];
         end
         BM_ONE: begin
            edge_lo = 1'b1;
            edge_hi = 1'b1;
         end
         default: ;
      endcase
   end

   // ext[i] is c[i-1], so ext[i +: 3] is the selector {c[i+1], c[i], c[i-1]}
   assign ext = {edge_hi, cells, edge_lo};

   always_comb begin
      nxt = '0;
      for (int unsigned i = 0; i < NUM_CELLS; i++) begin
         nxt[i] = rule[ext[i +: 3]];
      end
   end

endmodule

// File: rtl/eca_engine.sv
// Elementary cellular automaton engine: command-port controlled cell
// array with run/halt sequencing, generation counter and block read port.
module eca_engine
   import eca_pkg::*;
#(
   parameter int unsigned NUM_CELLS = 224,
   parameter int unsigned BLOCK_W   = 8,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                                              clk,
   input  logic                                              reset,
   input  logic                                              cmd_valid,
   output logic                                              cmd_ready,
   input  logic [2:0]                                        cmd_op,
   input  logic [ADDR_W-1:0]                                 cmd_addr,
   input  logic [((BLOCK_W > CNT_W) ? BLOCK_W : CNT_W)-1:0]  cmd_data,
   input  logic [ADDR_W-1:0]                                 rd_addr,
   output logic [BLOCK_W-1:0]                                rd_data,
   output logic                                              busy,
   output logic                                              done,
   output logic [CNT_W-1:0]                                  generation,
   output logic [7:0]                                        rule_o,
   output logic [1:0]                                        bmode_o
);

   localparam int unsigned NUM_BLOCKS = NUM_CELLS / BLOCK_W;

   state_t                 state, state_d;
   logic [NUM_CELLS-1:0]   cells, cells_d, step_out;
   logic [7:0]             rule, rule_d;
   logic [1:0]             bmode, bmode_d;
   logic [CNT_W-1:0]       gen_d;
   logic [CNT_W-1:0]       steps_left, steps_d;
   logic                   free_run, free_d;
   logic                   done_d;
   logic [BLOCK_W-1:0]     rd_d;
   logic                   accept;

   eca_step #(
      .NUM_CELLS (NUM_CELLS)
   ) u_step (
      .cells (cells),
      .rule  (rule),
      .bmode (bmode),
      .nxt   (step_out)
   );

   assign busy      = (state == ST_RUN);
   assign cmd_ready = (state == ST_IDLE) || (cmd_op == OP_HALT);
   assign accept    = cmd_valid && cmd_ready;
   assign rule_o    = rule;
   assign bmode_o   = bmode;

   always_comb begin
      state_d = state;
      cells_d = cells;
      rule_d  = rule;
      bmode_d = bmode;
      gen_d   = generation;
      steps_d = steps_left;
      free_d  = free_run;
      done_d  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               case (cmd_op)
                  OP_WRITE: begin
                     if (32'(cmd_addr) < NUM_BLOCKS)
                        cells_d[32'(cmd_addr) * BLOCK_W +: BLOCK_W] = cmd_data[BLOCK_W-1:0];
                  end
                  OP_SET_RULE:  rule_d  = cmd_data[7:0];
                  OP_SET_BMODE: bmode_d = cmd_data[1:0];
                  OP_RUN_N: begin
                     steps_d = cmd_data[CNT_W-1:0];
                     free_d  = 1'b0;
                     if (cmd_data[CNT_W-1:0] == '0)
                        done_d = 1'b1;
                     else
                        state_d = ST_RUN;
                  end
                  OP_RUN_FREE: begin
                     free_d  = 1'b1;
                     state_d = ST_RUN;
                  end
                  OP_CLEAR: begin
                     cells_d = '0;
                     gen_d   = '0;
                  end
                  default: ;
               endcase
            end
         end
         ST_RUN: begin
            // Only HALT can be accepted here; it pre-empts the step on this edge
            if (accept) begin
               state_d = ST_IDLE;
            end else begin
               cells_d = step_out;
               gen_d   = generation + CNT_W'(1);
               if (!free_run) begin
                  steps_d = steps_left - CNT_W'(1);
                  if (steps_left == CNT_W'(1)) begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Read port samples the state the cells take on this same edge
   always_comb begin
      rd_d = '0;
      if (32'(rd_addr) < NUM_BLOCKS)
         rd_d = cells_d[32'(rd_addr) * BLOCK_W +: BLOCK_W];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         cells      <= {{(NUM_CELLS-1){1'b0}}, 1'b1};
         rule       <= RESET_RULE;
         bmode      <= BM_WRAP;
         generation <= '0;
         steps_left <= '0;
         free_run   <= 1'b0;
         done       <= 1'b0;
         rd_data    <= '0;
      end else begin
         state      <= state_d;
         cells      <= cells_d;
         rule       <= rule_d;
         bmode      <= bmode_d;
         generation <= gen_d;
         steps_left <= steps_d;
         free_run   <= free_d;
         done       <= done_d;
         rd_data    <= rd_d;
      end
   end

endmodule

// File: tb/tb_eca_engine.sv
// Self-checking bench for eca_engine: directed vector table, hand-written
// run/halt/reset sequences and random commands against a cell-array model.
module tb_eca_engine;

   localparam int N      = 224;
   localparam int BW     = 8;
   localparam int AW     = 5;
   localparam int CW     = 16;
   localparam int DW     = 16;
   localparam int NBLK   = N / BW;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [2:0]    cmd_op = 3'd0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_data = '0;
   logic [AW-1:0] rd_addr = '0;
   logic [BW-1:0] rd_data;
   logic          busy;
   logic          done;
   logic [CW-1:0] generation;
   logic [7:0]    rule_o;
   logic [1:0]    bmode_o;

   eca_engine #(
      .NUM_CELLS (N),
      .BLOCK_W   (BW),
      .ADDR_W    (AW),
      .CNT_W     (CW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_addr   (cmd_addr),
      .cmd_data   (cmd_data),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .busy       (busy),
      .done       (done),
      .generation (generation),
      .rule_o     (rule_o),
      .bmode_o    (bmode_o)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // reference model: plain bit array, rule applied by neighbourhood lookup
   bit       m_cells [N];
   bit [7:0] m_rule;
   int       m_bmode;
   int       m_gen;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic m_reset();
      foreach (m_cells[i]) m_cells[i] = 1'b0;
      m_cells[0] = 1'b1;
      m_rule  = 8'd110;
      m_bmode = 0;
      m_gen   = 0;
   endtask

   function automatic int nb(input int j);
      if (j >= 0 && j < N) return int'(m_cells[j]);
      if (m_bmode == 0) return int'(m_cells[(j + N) % N]);
      if (m_bmode == 2) return 1;
      return 0;
   endfunction

   task automatic m_step();
      bit nx [N];
      for (int i = 0; i < N; i++) begin
         int idx;
         idx = 4 * nb(i + 1) + 2 * nb(i) + nb(i - 1);
         nx[i] = m_rule[idx];
      end
      m_cells = nx;
      m_gen = (m_gen + 1) % 65536;
   endtask

   function automatic int m_block(input int a);
      int v;
      v = 0;
      if (a >= NBLK) return 0;
      for (int b = 0; b < BW; b++) v += int'(m_cells[a * BW + b]) << b;
      return v;
   endfunction

   task automatic read_blk(input int a, output int v);
      @(negedge clk);
      rd_addr = AW'(a);
      @(posedge clk);
      @(posedge clk);
      #1 v = int'(rd_data);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      #2;
      @(negedge clk);
      reset = 1'b0;
      m_reset();
   endtask

   // issue one command from IDLE; RUN_N waits for completion and checks timing
   task automatic do_cmd(input logic [2:0] op, input int addr, input int data);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = AW'(addr);
      cmd_data  = DW'(data);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      case (op)
         3'd1: if (addr < NBLK) for (int b = 0; b < BW; b++) m_cells[addr * BW + b] = bit'((data >> b) & 1);
         3'd2: m_rule = 8'(data);
         3'd3: m_bmode = data & 3;
         3'd4: begin
            int k, n;
            k = data & 16'hFFFF;
            n = 0;
            if (k == 0) begin
               chk("run0_done", int'(done), 1);
               chk("run0_busy", int'(busy), 0);
            end else begin
               while (busy && n < k + 5) begin
                  n++;
                  @(posedge clk);
                  #1;
               end
               chk("run_busy_cycles", n, k);
               chk("run_done_pulse", int'(done), 1);
               for (int s = 0; s < k; s++) m_step();
            end
            @(posedge clk);
            #1 chk("done_single_cycle", int'(done), 0);
         end
         3'd7: begin
            foreach (m_cells[i]) m_cells[i] = 1'b0;
            m_gen = 0;
         end
         default: ;
      endcase
   endtask

   typedef struct {
      logic [2:0] op;
      int         addr;
      int         data;
      int         rd;
      int         exp_rd;
      int         exp_gen;
   } vec_t;

   vec_t vecs [9];

   initial begin
      int v;

      vecs[0] = '{3'd0, 0,  0,     0,  8'h01, 0};
      vecs[1] = '{3'd4, 0,  1,     0,  8'h03, 1};
      vecs[2] = '{3'd0, 0,  0,     27, 8'h00, 1};
      vecs[3] = '{3'd4, 0,  1,     0,  8'h07, 2};
      vecs[4] = '{3'd7, 0,  0,     0,  8'h00, 0};
      vecs[5] = '{3'd1, 3,  8'hA5, 3,  8'hA5, 0};
      vecs[6] = '{3'd1, 31, 8'hFF, 3,  8'hA5, 0};
      vecs[7] = '{3'd0, 0,  0,     0,  8'h00, 0};
      vecs[8] = '{3'd4, 0,  0,     3,  8'hA5, 0};

      // reset values
      reset = 1'b1;
      #12;
      chk("rst_rd_data", int'(rd_data), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_gen", int'(generation), 0);
      chk("rst_rule", int'(rule_o), 8'h6E);
      chk("rst_bmode", int'(bmode_o), 0);
      chk("rst_ready", int'(cmd_ready), 1);
      @(negedge clk);
      reset = 1'b0;
      m_reset();

      for (int i = 0; i < 9; i++) begin
         do_cmd(vecs[i].op, vecs[i].addr, vecs[i].data);
         read_blk(vecs[i].rd, v);
         chk($sformatf("vec%0d_rd", i), v, vecs[i].exp_rd);
         chk($sformatf("vec%0d_gen", i), int'(generation), vecs[i].exp_gen);
      end

      // rule 0x5A under WRAP and ZERO boundaries
      for (int m = 0; m < 2; m++) begin
         do_reset();
         do_cmd(3'd2, 0, 8'h5A);
         if (m == 1) do_cmd(3'd3, 0, 1);
         do_cmd(3'd4, 0, 1);
         read_blk(0, v);
         chk($sformatf("r5a_m%0d_blk0", m), v, 8'h02);
         read_blk(27, v);
         chk($sformatf("r5a_m%0d_blk27", m), v, (m == 0) ? 8'h80 : 8'h00);
      end

      // free run with a stalled WRITE, HALT after 10 steps, then WRITE lands
      do_reset();
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 3'd5;
      @(posedge clk);
      #1;
      cmd_op   = 3'd1;
      cmd_addr = AW'(0);
      cmd_data = DW'(8'hFF);
      chk("free_busy", int'(busy), 1);
      chk("free_ready_low", int'(cmd_ready), 0);
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
      end
      chk("free_gen10", int'(generation), 10);
      cmd_op = 3'd6;
      @(posedge clk);
      #1;
      chk("halt_busy", int'(busy), 0);
      chk("halt_gen", int'(generation), 10);
      chk("halt_no_done", int'(done), 0);
      cmd_op = 3'd1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      chk("halt_no_done2", int'(done), 0);
      for (int s = 0; s < 10; s++) m_step();
      for (int b = 0; b < BW; b++) m_cells[b] = 1'b1;
      for (int a = 0; a < NBLK; a++) begin
         read_blk(a, v);
         chk($sformatf("halt_blk%0d", a), v, m_block(a));
      end

      // asynchronous reset in the middle of a long run
      do_reset();
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 3'd4;
      cmd_data  = DW'(1000);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      repeat (500) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("arst_busy", int'(busy), 0);
      chk("arst_gen", int'(generation), 0);
      chk("arst_done", int'(done), 0);
      chk("arst_rule", int'(rule_o), 8'h6E);
      chk("arst_rd", int'(rd_data), 0);
      @(negedge clk);
      reset = 1'b0;
      m_reset();
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1 chk("arst_no_done", int'(done), 0);
      end
      read_blk(0, v);
      chk("arst_blk0", v, 8'h01);

      // random commands against the model
      for (int it = 0; it < 60; it++) begin
         int sel, a;
         sel = $urandom_range(0, 9);
         case (sel)
            0, 1, 2: do_cmd(3'd1, $urandom_range(0, 31), $urandom_range(0, 255));
            3:       do_cmd(3'd2, 0, $urandom_range(0, 255));
            4:       do_cmd(3'd3, 0, $urandom_range(0, 3));
            5:       do_cmd(3'd7, 0, 0);
            6:       do_cmd(3'd0, 0, 0);
            default: do_cmd(3'd4, 0, $urandom_range(0, 6));
         endcase
         a = $urandom_range(0, 31);
         read_blk(a, v);
         chk($sformatf("rnd%0d_blk%0d", it, a), v, m_block(a));
         chk($sformatf("rnd%0d_gen", it), int'(generation), m_gen);
         chk($sformatf("rnd%0d_rule", it), int'(rule_o), int'(m_rule));
         chk($sformatf("rnd%0d_bmode", it), int'(bmode_o), m_bmode);
      end
      for (int a = 0; a < NBLK; a++) begin
         read_blk(a, v);
         chk($sformatf("final_blk%0d", a), v, m_block(a));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
